// File: rtl/sliding_window_buffer_pkg.sv
// Shared types and helpers for the sliding window buffer.
//
// Contents:
//   state_t          framing state machine encoding (IDLE / ACTIVE)
//   DEFAULT_*        default build parameters for the top module
//   half_win()       distance from the window edge to its centre
//   ram_addr_bits()  address width needed to index one line RAM
package sliding_window_buffer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_WIN          = 3;
  localparam int DEFAULT_FRAME_WIDTH  = 640;
  localparam int DEFAULT_FRAME_HEIGHT = 480;
  localparam int DEFAULT_ADDR_WIDTH   = 11;

  function automatic int half_win(input int win);
    return (win - 1) / 2;
  endfunction

  // A single-entry RAM still needs one address bit to keep port widths legal.
  function automatic int ram_addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sliding_window_buffer_line_ram.sv
// One row of pixel storage for the sliding window buffer.
//
// Asynchronous read, synchronous write-enable, no reset: contents after
// power-up are undefined and are always overwritten before they are used.
//
// Ports:
//   clk      in   clock, write on posedge
//   we       in   write enable
//   addr     in   common read/write address (pixel column)
//   wr_data  in   value stored at addr when we=1
//   rd_data  out  current contents of addr (value before any same-cycle write)
module sliding_window_buffer_line_ram #(
  parameter int DEPTH      = 640,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Combinational read gives read-before-write semantics when the same
  // address is written on the upcoming edge.
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sliding_window_buffer.sv
// Line buffer and WIN x WIN window generator for a raster pixel stream.
//
// Each accepted pixel is written into a chain of WIN-1 line RAMs and shifted
// into a WIN x WIN register array. Once the pixel position is at least WIN-1
// into both the row and the column, the array holds a window fully inside
// the current frame and win_valid pulses for one cycle with the window-centre
// coordinates.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   en         in   pipeline advance; 0 = stall
//   in_valid   in   in_data carries a pixel
//   in_sof     in   first pixel of a frame (only meaningful with in_valid)
//   in_data    in   pixel value
//   win_out    out  window, element (r,c) at [(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH],
//                   r=0 oldest row, c=0 oldest column
//   win_valid  out  one-cycle pulse: win_out is a fully in-frame window
//   win_x      out  window-centre column
//   win_y      out  window-centre row
//   win_last   out  pulses with win_valid on the last window of the frame
//   sof_err    out  sticky framing error, cleared only by reset
module sliding_window_buffer
  import sliding_window_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int WIN          = DEFAULT_WIN,
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic                           in_valid,
  input  logic                           in_sof,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic [WIN*WIN*DATA_WIDTH-1:0]  win_out,
  output logic                           win_valid,
  output logic [ADDR_WIDTH-1:0]          win_x,
  output logic [ADDR_WIDTH-1:0]          win_y,
  output logic                           win_last,
  output logic                           sof_err
);

  localparam int H      = half_win(WIN);
  localparam int RAM_AW = ram_addr_bits(FRAME_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] EDGE     = ADDR_WIDTH'(WIN - 1);
  localparam logic [ADDR_WIDTH-1:0] HALF     = ADDR_WIDTH'(H);

  state_t state;
  state_t state_next;

  // col/row hold the position the next in-frame pixel will occupy.
  logic [ADDR_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0] row;

  logic accept;
  logic pix_ok;
  logic restart;
  logic framing_err;

  logic [ADDR_WIDTH-1:0] cur_col;
  logic [ADDR_WIDTH-1:0] cur_row;
  logic                  at_last_col;
  logic                  frame_end;
  logic                  win_ready;

  logic [WIN-2:0][DATA_WIDTH-1:0] tap_rd;
  logic [WIN-2:0][DATA_WIDTH-1:0] tap_wr;
  logic [RAM_AW-1:0]              ram_addr;

  // Packed so that element (r,c) lands at bit offset (r*WIN+c)*DATA_WIDTH.
  logic [WIN-1:0][WIN-1:0][DATA_WIDTH-1:0] win_reg;

  assign accept = en & in_valid;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Framing decode: decides whether the accepted pixel belongs to a frame,
  // whether it restarts one at (0,0), and whether that is a framing error.
  // A start-of-frame anywhere but (0,0) while active is a resync.
  always_comb begin
    pix_ok      = 1'b0;
    restart     = 1'b0;
    framing_err = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (in_sof) begin
            pix_ok  = 1'b1;
            restart = 1'b1;
          end else begin
            framing_err = 1'b1;
          end
        end
        ST_ACTIVE: begin
          pix_ok = 1'b1;
          if (in_sof) begin
            restart = 1'b1;
            if ((col != '0) || (row != '0)) begin
              framing_err = 1'b1;
            end
          end
        end
        default: begin
          pix_ok = 1'b0;
        end
      endcase
    end
  end

  // Position of the pixel being accepted this cycle.
  assign cur_col     = restart ? '0 : col;
  assign cur_row     = restart ? '0 : row;
  assign at_last_col = (cur_col == LAST_COL);
  assign frame_end   = pix_ok & at_last_col & (cur_row == LAST_ROW);
  assign win_ready   = pix_ok & (cur_col >= EDGE) & (cur_row >= EDGE);

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pix_ok && !frame_end) begin
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (frame_end) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Raster position counters; cleared at the end of every frame so IDLE
  // always sits at (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_ok) begin
      if (frame_end) begin
        col <= '0;
        row <= '0;
      end else if (at_last_col) begin
        col <= '0;
        row <= cur_row + ADDR_WIDTH'(1);
      end else begin
        col <= cur_col + ADDR_WIDTH'(1);
        row <= cur_row;
      end
    end
  end

  // Line RAM chain: tap 0 is the previous row, tap k is k+1 rows back.
  // Every tap forwards its old contents to the next one on the same write.
  assign ram_addr = cur_col[RAM_AW-1:0];

  for (genvar k = 0; k < WIN - 1; k++) begin : g_line
    if (k == 0) begin : g_head
      assign tap_wr[k] = in_data;
    end else begin : g_chain
      assign tap_wr[k] = tap_rd[k-1];
    end

    sliding_window_buffer_line_ram #(
      .DEPTH      (FRAME_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (RAM_AW)
    ) u_line_ram (
      .clk     (clk),
      .we      (pix_ok),
      .addr    (ram_addr),
      .wr_data (tap_wr[k]),
      .rd_data (tap_rd[k])
    );
  end

  // Window shift: columns move one place towards c=0; the new column takes
  // the oldest row from the deepest tap and the newest row from in_data.
  // Columns left over from the previous row still shift in; they are
  // harmless because win_ready waits for col >= WIN-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_reg <= '0;
    end else if (pix_ok) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
      end
      for (int r = 0; r < WIN - 1; r++) begin
        win_reg[r][WIN-1] <= tap_rd[WIN-2-r];
      end
      win_reg[WIN-1][WIN-1] <= in_data;
    end
  end

  assign win_out = win_reg;

  // Output flags and centre coordinates. Coordinates only move on a valid
  // window, so they hold across stalls and bubbles. The subtraction cannot
  // underflow because win_ready requires col,row >= WIN-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      sof_err   <= 1'b0;
    end else begin
      win_valid <= win_ready;
      win_last  <= win_ready & frame_end;
      if (win_ready) begin
        win_x <= cur_col - HALF;
        win_y <= cur_row - HALF;
      end
      if (framing_err) begin
        sof_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed testbench for sliding_window_buffer on an 8x6 frame.
// Pixel data is row*16+col, so every window element can be predicted from
// its frame position alone. A WIN=3 and a WIN=5 build share the stimulus.
module tb_sliding_window_buffer;

  localparam int DW = 8;
  localparam int AW = 11;
  localparam int FW = 8;
  localparam int FH = 6;

  logic          clk;
  logic          reset_n;
  logic          en;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_data;

  logic [3*3*DW-1:0] win_out3;
  logic              win_valid3;
  logic [AW-1:0]     win_x3;
  logic [AW-1:0]     win_y3;
  logic              win_last3;
  logic              sof_err3;

  logic [5*5*DW-1:0] win_out5;
  logic              win_valid5;
  logic [AW-1:0]     win_x5;
  logic [AW-1:0]     win_y5;
  logic              win_last5;
  logic              sof_err5;

  int n_cmp;
  int n_bad;

  sliding_window_buffer #(
    .DATA_WIDTH(DW), .WIN(3), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .ADDR_WIDTH(AW)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .win_out(win_out3), .win_valid(win_valid3), .win_x(win_x3),
    .win_y(win_y3), .win_last(win_last3), .sof_err(sof_err3)
  );

  sliding_window_buffer #(
    .DATA_WIDTH(DW), .WIN(5), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .ADDR_WIDTH(AW)
  ) dut5 (
    .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .win_out(win_out5), .win_valid(win_valid5), .win_x(win_x5),
    .win_y(win_y5), .win_last(win_last5), .sof_err(sof_err5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected window for the pixel at (col,row): element (r,c) comes from
  // frame position (col-(w-1)+c, row-(w-1)+r).
  function automatic logic [199:0] exp_window(input int col, input int row, input int w,
                                              input int offset);
    logic [199:0] v;
    int val;
    v = '0;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        val = offset + (row - (w - 1) + r) * 16 + (col - (w - 1) + c);
        v[(r*w+c)*8 +: 8] = 8'(val);
      end
    end
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge; return 1 time unit after
  // the following rising edge so outputs can be sampled.
  task automatic drive_cycle(input logic e, input logic v, input logic s, input logic [DW-1:0] d);
    @(negedge clk);
    en       = e;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (win_out3 !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_win_out: got %h want 0", win_out3);
    end
    n_cmp++;
    if ({win_valid3, win_last3, sof_err3} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got %b want 000", {win_valid3, win_last3, sof_err3});
    end
    n_cmp++;
    if (win_x3 !== '0 || win_y3 !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_xy: got (%0d,%0d) want (0,0)", win_x3, win_y3);
    end
    n_cmp++;
    if (win_valid5 !== 1'b0 || win_out5 !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_win5: got valid %b out %h want 0", win_valid5, win_out5);
    end
  endtask

  // Full ramp frame with sof on pixel 0 and en held high.
  task automatic test_ramp_frame(input string tag);
    int pulses;
    logic exp_v;
    logic [199:0] ew;
    pulses = 0;
    for (int row = 0; row < FH; row++) begin
      for (int col = 0; col < FW; col++) begin
        drive_cycle(1'b1, 1'b1, (row == 0 && col == 0), 8'(row * 16 + col));
        exp_v = (col >= 2 && row >= 2);
        n_cmp++;
        if (win_valid3 !== exp_v) begin
          n_bad++;
          $display("[TB] FAIL %s_valid (%0d,%0d): got %b want %b", tag, col, row, win_valid3, exp_v);
        end
        n_cmp++;
        if (win_last3 !== (exp_v && col == FW - 1 && row == FH - 1)) begin
          n_bad++;
          $display("[TB] FAIL %s_last (%0d,%0d): got %b", tag, col, row, win_last3);
        end
        if (win_valid3 === 1'b1) pulses++;
        if (exp_v) begin
          ew = exp_window(col, row, 3, 0);
          n_cmp++;
          if (win_out3 !== ew[71:0]) begin
            n_bad++;
            $display("[TB] FAIL %s_window (%0d,%0d): got %h want %h", tag, col, row, win_out3, ew[71:0]);
          end
          n_cmp++;
          if (win_x3 !== AW'(col - 1) || win_y3 !== AW'(row - 1)) begin
            n_bad++;
            $display("[TB] FAIL %s_centre (%0d,%0d): got (%0d,%0d) want (%0d,%0d)",
                     tag, col, row, win_x3, win_y3, col - 1, row - 1);
          end
        end
        if (col == 2 && row == 2) begin
          n_cmp++;
          if (win_out3[0 +: 8] !== 8'h00 || win_out3[32 +: 8] !== 8'h11 || win_out3[64 +: 8] !== 8'h22) begin
            n_bad++;
            $display("[TB] FAIL %s_first_window: got %h,%h,%h want 00,11,22", tag,
                     win_out3[0 +: 8], win_out3[32 +: 8], win_out3[64 +: 8]);
          end
        end
      end
    end
    n_cmp++;
    if (pulses !== 24) begin
      n_bad++;
      $display("[TB] FAIL %s_pulse_count: got %0d want 24", tag, pulses);
    end
  endtask

  task automatic test_clean_frame();
    test_ramp_frame("ramp");
    n_cmp++;
    if (sof_err3 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ramp_sof_err: got %b want 0", sof_err3);
    end
  endtask

  // Same frame with stalls (en=0) and bubbles (in_valid=0). Non-accepted
  // cycles carry junk data and sof to prove they are ignored.
  task automatic test_gapped_frame();
    bit [1:0] pat [8];
    int idx, col, row, pulses, hold_x, hold_y;
    logic e, v, exp_v;
    logic [199:0] ew;
    pat = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b11};
    idx = 0;
    pulses = 0;
    hold_x = 6;
    hold_y = 4;
    for (int cyc = 0; cyc < 400 && idx < FW * FH; cyc++) begin
      e = pat[cyc % 8][1];
      v = pat[cyc % 8][0];
      col = idx % FW;
      row = idx / FW;
      if (e && v) begin
        drive_cycle(1'b1, 1'b1, (idx == 0), 8'(row * 16 + col));
        exp_v = (col >= 2 && row >= 2);
        n_cmp++;
        if (win_valid3 !== exp_v) begin
          n_bad++;
          $display("[TB] FAIL gap_valid (%0d,%0d): got %b want %b", col, row, win_valid3, exp_v);
        end
        if (win_valid3 === 1'b1) pulses++;
        if (exp_v) begin
          ew = exp_window(col, row, 3, 0);
          n_cmp++;
          if (win_out3 !== ew[71:0] || win_x3 !== AW'(col - 1) || win_y3 !== AW'(row - 1)) begin
            n_bad++;
            $display("[TB] FAIL gap_window (%0d,%0d): got %h @(%0d,%0d) want %h", col, row,
                     win_out3, win_x3, win_y3, ew[71:0]);
          end
          hold_x = col - 1;
          hold_y = row - 1;
        end
        idx++;
      end else begin
        drive_cycle(e, v, 1'b1, 8'hEE);
        n_cmp++;
        if (win_valid3 !== 1'b0 || win_last3 !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL gap_bubble_valid cyc %0d: got %b want 0", cyc, win_valid3);
        end
        n_cmp++;
        if (win_x3 !== AW'(hold_x) || win_y3 !== AW'(hold_y)) begin
          n_bad++;
          $display("[TB] FAIL gap_hold_xy cyc %0d: got (%0d,%0d) want (%0d,%0d)", cyc,
                   win_x3, win_y3, hold_x, hold_y);
        end
      end
    end
    n_cmp++;
    if (pulses !== 24) begin
      n_bad++;
      $display("[TB] FAIL gap_pulse_count: got %0d want 24", pulses);
    end
  endtask

  // sof re-asserted on pixel (3,2): the new frame uses data offset 0x80 so
  // any old-frame value in a window is detectable.
  task automatic test_sof_resync();
    int col, row, pulses;
    logic exp_v;
    logic [199:0] ew;
    for (int idx = 0; idx < 2 * FW + 3; idx++) begin
      drive_cycle(1'b1, 1'b1, (idx == 0), 8'((idx / FW) * 16 + idx % FW));
    end
    n_cmp++;
    if (win_valid3 !== 1'b1 || sof_err3 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL resync_pre: got valid %b err %b want 1 0", win_valid3, sof_err3);
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h80);
    n_cmp++;
    if (sof_err3 !== 1'b1 || win_valid3 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL resync_err: got err %b valid %b want 1 0", sof_err3, win_valid3);
    end
    pulses = 0;
    for (int idx = 1; idx < FW * FH; idx++) begin
      col = idx % FW;
      row = idx / FW;
      drive_cycle(1'b1, 1'b1, 1'b0, 8'(128 + row * 16 + col));
      exp_v = (col >= 2 && row >= 2);
      n_cmp++;
      if (win_valid3 !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL resync_valid (%0d,%0d): got %b want %b", col, row, win_valid3, exp_v);
      end
      if (win_valid3 === 1'b1) pulses++;
      if (exp_v) begin
        ew = exp_window(col, row, 3, 128);
        n_cmp++;
        if (win_out3 !== ew[71:0]) begin
          n_bad++;
          $display("[TB] FAIL resync_window (%0d,%0d): got %h want %h", col, row, win_out3, ew[71:0]);
        end
      end
    end
    n_cmp++;
    if (pulses !== 24 || win_last3 !== 1'b1 || sof_err3 !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL resync_end: got pulses %0d last %b err %b want 24 1 1", pulses, win_last3, sof_err3);
    end
  endtask

  task automatic test_no_sof();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 8'(64 + i));
      n_cmp++;
      if (win_valid3 !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL nosof_valid %0d: got %b want 0", i, win_valid3);
      end
    end
    n_cmp++;
    if (sof_err3 !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL nosof_err: got %b want 1", sof_err3);
    end
    test_ramp_frame("after_drop");
    n_cmp++;
    if (sof_err3 !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL nosof_sticky: got %b want 1", sof_err3);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive_cycle(1'b1, 1'b1, 1'b0, 8'h55);
    for (int idx = 0; idx <= 3 * FW + 4; idx++) begin
      drive_cycle(1'b1, 1'b1, (idx == 0), 8'((idx / FW) * 16 + idx % FW));
    end
    n_cmp++;
    if (win_valid3 !== 1'b1 || win_x3 !== AW'(3) || sof_err3 !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL areset_pre: got valid %b x %0d err %b want 1 3 1", win_valid3, win_x3, sof_err3);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (win_out3 !== '0 || win_x3 !== '0 || win_y3 !== '0) begin
      n_bad++;
      $display("[TB] FAIL areset_data: got %h (%0d,%0d) want 0", win_out3, win_x3, win_y3);
    end
    n_cmp++;
    if ({win_valid3, win_last3, sof_err3} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL areset_flags: got %b want 000", {win_valid3, win_last3, sof_err3});
    end
    en       = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    test_ramp_frame("after_reset");
  endtask

  task automatic test_win5();
    int pulses;
    logic exp_v;
    logic [199:0] ew;
    pulses = 0;
    for (int row = 0; row < FH; row++) begin
      for (int col = 0; col < FW; col++) begin
        drive_cycle(1'b1, 1'b1, (row == 0 && col == 0), 8'(row * 16 + col));
        exp_v = (col >= 4 && row >= 4);
        n_cmp++;
        if (win_valid5 !== exp_v || win_last5 !== (exp_v && col == FW - 1 && row == FH - 1)) begin
          n_bad++;
          $display("[TB] FAIL win5_flags (%0d,%0d): got valid %b last %b want %b", col, row,
                   win_valid5, win_last5, exp_v);
        end
        if (win_valid5 === 1'b1) pulses++;
        if (exp_v) begin
          ew = exp_window(col, row, 5, 0);
          n_cmp++;
          if (win_out5 !== ew || win_x5 !== AW'(col - 2) || win_y5 !== AW'(row - 2)) begin
            n_bad++;
            $display("[TB] FAIL win5_window (%0d,%0d): got %h @(%0d,%0d) want %h", col, row,
                     win_out5, win_x5, win_y5, ew);
          end
        end
        if (col == 4 && row == 4) begin
          n_cmp++;
          if (win_out5[12*8 +: 8] !== 8'h22 || win_x5 !== AW'(2) || win_y5 !== AW'(2)) begin
            n_bad++;
            $display("[TB] FAIL win5_first_centre: got %h @(%0d,%0d) want 22 @(2,2)",
                     win_out5[12*8 +: 8], win_x5, win_y5);
          end
        end
      end
    end
    n_cmp++;
    if (pulses !== 8 || win_x5 !== AW'(5) || win_y5 !== AW'(3)) begin
      n_bad++;
      $display("[TB] FAIL win5_end: got pulses %0d last centre (%0d,%0d) want 8 (5,3)", pulses, win_x5, win_y5);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_clean_frame();
    test_gapped_frame();
    test_sof_resync();
    test_no_sof();
    test_async_reset();
    test_win5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
